inst_fetch: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Each cycle it takes the current pc/ce, issues a pipelined request to instruction memory, and tracks outstanding requests.
- Returned words are buffered in order with their PCs and loaded into the IF/ID pipeline register that feeds decode.
- Raises a stall request to the pipeline controller whenever the current PC cannot be issued, so the PC holds.

---
 rtl/inst_fetch.sv | 149 ++++++++++++++
 tb/tb_inst_fetch.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues pipelined instruction-memory requests under a credit
// limit, buffers in-order responses with their PCs and drives the IF/ID register.
module inst_fetch #(
  parameter int          OUTSTANDING = 2,
  parameter logic [31:0] NOP_INST    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ce,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        stallreq_if,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int OW = CW + 2;

  logic [31:0]   pend_mem [OUTSTANDING];
  logic [PW-1:0] pend_rd;
  logic [PW-1:0] pend_wr;
  logic [CW-1:0] pend_cnt;

  logic [63:0]   rbuf_mem [OUTSTANDING];
  logic [PW-1:0] rbuf_rd;
  logic [PW-1:0] rbuf_wr;
  logic [CW-1:0] rbuf_cnt;

  logic [CW-1:0] drop_cnt;
  logic [OW-1:0] occ;
  logic [OW-1:0] drop_sum;
  logic          fetch_ok;
  logic          grant;
  logic          rsp_accept;
  logic          rsp_drop;
  logic          rbuf_pop;
  logic [63:0]   rbuf_head;
  logic          unused_stall;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rbuf_pop = ~flush & ~stall[1] & (rbuf_cnt != '0);

  // An entry leaving for decode this cycle frees its credit at once, which is what
  // sustains one fetch per cycle with single-cycle memory latency.
  assign occ = OW'(pend_cnt) + OW'(rbuf_cnt) + OW'(drop_cnt) - OW'(rbuf_pop);

  assign fetch_ok    = rst & ce & ~flush;
  assign imem_req    = fetch_ok & (occ < OW'(OUTSTANDING));
  assign imem_addr   = pc;
  assign grant       = imem_req & imem_gnt;
  assign stallreq_if = fetch_ok & ~grant;

  assign rsp_drop   = imem_rvalid & (drop_cnt != '0);
  assign rsp_accept = imem_rvalid & ~flush & (drop_cnt == '0) & (pend_cnt != '0);
  assign rbuf_head  = rbuf_mem[rbuf_rd];

  // Everything still outstanding at a flush must be swallowed when it returns.
  assign drop_sum = OW'(drop_cnt) + OW'(pend_cnt)
                  - OW'(imem_rvalid & ((drop_cnt != '0) | (pend_cnt != '0)));

  assign unused_stall = ^{stall[5:3], stall[0]};

  always_ff @(posedge clk) begin
    if (grant)
      pend_mem[pend_wr] <= pc;
    if (rsp_accept)
      rbuf_mem[rbuf_wr] <= {pend_mem[pend_rd], imem_rdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_rd  <= '0;
      pend_wr  <= '0;
      pend_cnt <= '0;
    end else if (flush) begin
      pend_rd  <= '0;
      pend_wr  <= '0;
      pend_cnt <= '0;
    end else begin
      if (grant)
        pend_wr <= ptr_inc(pend_wr);
      if (rsp_accept)
        pend_rd <= ptr_inc(pend_rd);
      pend_cnt <= pend_cnt + CW'(grant) - CW'(rsp_accept);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbuf_rd  <= '0;
      rbuf_wr  <= '0;
      rbuf_cnt <= '0;
    end else if (flush) begin
      rbuf_rd  <= '0;
      rbuf_wr  <= '0;
      rbuf_cnt <= '0;
    end else begin
      if (rsp_accept)
        rbuf_wr <= ptr_inc(rbuf_wr);
      if (rbuf_pop)
        rbuf_rd <= ptr_inc(rbuf_rd);
      rbuf_cnt <= rbuf_cnt + CW'(rsp_accept) - CW'(rbuf_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt <= '0;
    else if (flush)
      drop_cnt <= drop_sum[CW-1:0];
    else if (rsp_drop)
      drop_cnt <= drop_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc    <= '0;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (flush || (stall[1] && !stall[2])) begin
      id_pc    <= '0;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (!stall[1]) begin
      if (rbuf_cnt != '0) begin
        id_pc    <= rbuf_head[63:32];
        id_inst  <= rbuf_head[31:0];
        id_valid <= 1'b1;
      end else begin
        id_pc    <= '0;
        id_inst  <= NOP_INST;
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: queue-based reference model compared every
// cycle, a responder modelling in-order 1-cycle memory, and directed scenarios.
module tb_inst_fetch;

  localparam int OUTSTANDING = 2;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stallreq_if;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] m_pend [$];
  logic [63:0] m_buf [$];
  int          m_drop = 0;
  logic [31:0] m_id_pc = 32'h0;
  logic [31:0] m_id_inst = 32'h0;
  logic        m_id_valid = 1'b0;
  logic [63:0] m_ent;
  logic        m_taken;

  logic [31:0] mem_q [$];
  logic        mem_grant = 1'b0;
  logic [31:0] mem_grant_addr = 32'h0;

  inst_fetch #(.OUTSTANDING(OUTSTANDING), .NOP_INST(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce), .stall(stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stallreq_if(stallreq_if),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    case (a)
      32'h00:  return 32'h11;
      32'h04:  return 32'h22;
      32'h08:  return 32'h33;
      32'h20:  return 32'hAA;
      default: return 32'hDEAD_0000 | a;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Credit rule: pending + buffered + still-to-drop, less the entry decode takes now.
  function automatic logic model_req();
    int occ;
    occ = m_pend.size() + m_buf.size() + m_drop;
    if (!flush && !stall[1] && m_buf.size() > 0) occ--;
    return rst && ce && !flush && (occ < OUTSTANDING);
  endfunction

  task automatic model_clear();
    m_pend.delete();
    m_buf.delete();
    mem_q.delete();
    m_drop     = 0;
    m_id_pc    = 32'h0;
    m_id_inst  = 32'h0;
    m_id_valid = 1'b0;
  endtask

  always @(negedge rst) model_clear();

  always @(posedge clk) begin
    if (!rst) begin
      model_clear();
    end else begin
      m_taken = model_req() && imem_gnt;
      if (flush) begin
        m_drop = m_drop + m_pend.size();
        if (imem_rvalid && m_drop > 0) m_drop--;
        m_pend.delete();
        m_buf.delete();
        m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
      end else begin
        if (stall[1] && !stall[2]) begin
          m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
        end else if (!stall[1]) begin
          if (m_buf.size() > 0) begin
            m_ent = m_buf.pop_front();
            m_id_pc = m_ent[63:32]; m_id_inst = m_ent[31:0]; m_id_valid = 1;
          end else begin
            m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
          end
        end
        if (imem_rvalid) begin
          if (m_drop > 0) m_drop--;
          else if (m_pend.size() > 0) m_buf.push_back({m_pend.pop_front(), imem_rdata});
        end
        if (m_taken) m_pend.push_back(pc);
      end
      if (mem_grant) mem_q.push_back(mem_grant_addr);
      if (imem_rvalid && mem_q.size() > 0) mem_q.delete(0);
    end
  end

  always @(negedge clk) begin
    mem_grant      = imem_req && imem_gnt;
    mem_grant_addr = imem_addr;
    if (!rst) begin
      check_output("rst_imem_req", imem_req, 0);
      check_output("rst_stallreq", stallreq_if, 0);
      check_output("rst_id_valid", id_valid, 0);
      check_output("rst_id_inst", id_inst, 0);
    end else begin
      check_output("imem_req", imem_req, model_req());
      check_output("stallreq_if", stallreq_if, rst && ce && !flush && !(model_req() && imem_gnt));
      check_output("imem_addr", imem_addr, pc);
      check_output("id_valid", id_valid, m_id_valid);
      check_output("id_pc", id_pc, m_id_pc);
      check_output("id_inst", id_inst, m_id_inst);
      check_output("rvalid_legal", imem_rvalid && m_drop == 0 && m_pend.size() == 0, 0);
    end
  end

  task automatic apply_stimulus(input logic [31:0] a_pc, input logic a_ce, input logic [5:0] a_stall,
                                input logic a_flush, input logic a_gnt, input logic a_resp);
    pc = a_pc; ce = a_ce; stall = a_stall; flush = a_flush; imem_gnt = a_gnt;
    if (a_resp && rst && mem_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inst_of(mem_q[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(32'h0, 1'b0, 6'b0, 1'b0, 1'b1, 1'b1);
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; pc = 32'h0; ce = 1'b0; stall = 6'b0; flush = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    tick();
    check_output("reset_id_valid", id_valid, 0);
    check_output("reset_id_pc", id_pc, 0);
    check_output("reset_id_inst", id_inst, 0);
    check_output("reset_imem_req", imem_req, 0);
    rst = 1'b1;

    $display("[TB] streaming");
    apply_stimulus(32'h00, 1, 6'b0, 0, 1, 1); #3;
    check_output("s0_req", imem_req, 1);
    check_output("s0_stallreq", stallreq_if, 0);
    tick();
    apply_stimulus(32'h04, 1, 6'b0, 0, 1, 1); #3;
    check_output("s1_req", imem_req, 1);
    check_output("s1_stallreq", stallreq_if, 0);
    tick();
    apply_stimulus(32'h08, 1, 6'b0, 0, 1, 1); #3;
    check_output("s2_req", imem_req, 1);
    check_output("s2_stallreq", stallreq_if, 0);
    check_output("s2_id_valid", id_valid, 0);
    tick();
    check_output("s3_id_valid", id_valid, 1);
    check_output("s3_id_pc", id_pc, 32'h00);
    check_output("s3_id_inst", id_inst, 32'h11);
    apply_stimulus(32'h0C, 0, 6'b0, 0, 1, 1); tick();
    check_output("s4_id_pc", id_pc, 32'h04);
    check_output("s4_id_inst", id_inst, 32'h22);
    apply_stimulus(32'h0C, 0, 6'b0, 0, 1, 1); tick();
    check_output("s5_id_pc", id_pc, 32'h08);
    check_output("s5_id_inst", id_inst, 32'h33);
    apply_stimulus(32'h0C, 0, 6'b0, 0, 1, 1); tick();
    check_output("s6_id_valid", id_valid, 0);
    drain(2);

    $display("[TB] grant backpressure");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(32'h10, 1, 6'b0, 0, 0, 1); #3;
      check_output("bp_stallreq", stallreq_if, 1);
      check_output("bp_addr", imem_addr, 32'h10);
      tick();
    end
    apply_stimulus(32'h10, 1, 6'b0, 0, 1, 1); #3;
    check_output("bp_gnt_req", imem_req, 1);
    check_output("bp_gnt_stallreq", stallreq_if, 0);
    tick();
    drain(1);
    check_output("bp_id_valid", id_valid, 0);
    drain(1);
    check_output("bp_id_pc", id_pc, 32'h10);
    check_output("bp_id_inst", id_inst, 32'hDEAD_0010);
    drain(1);
    check_output("bp_once", id_valid, 0);
    drain(2);

    $display("[TB] credit limit");
    apply_stimulus(32'h40, 1, 6'b0, 0, 1, 0); tick();
    apply_stimulus(32'h44, 1, 6'b0, 0, 1, 0); #3;
    check_output("cr_second_req", imem_req, 1);
    tick();
    apply_stimulus(32'h48, 1, 6'b0, 0, 1, 0); #3;
    check_output("cr_full_req", imem_req, 0);
    check_output("cr_full_stallreq", stallreq_if, 1);
    tick();
    apply_stimulus(32'h48, 1, 6'b0, 0, 1, 1); #3;
    check_output("cr_rvalid_req", imem_req, 0);
    tick();
    apply_stimulus(32'h48, 1, 6'b0, 0, 1, 0); #3;
    check_output("cr_resume_req", imem_req, 1);
    check_output("cr_resume_stallreq", stallreq_if, 0);
    tick();
    check_output("cr_id_pc", id_pc, 32'h40);
    drain(5);

    $display("[TB] decode stall");
    apply_stimulus(32'h1C, 1, 6'b0, 0, 1, 1); tick();
    apply_stimulus(32'h20, 1, 6'b0, 0, 1, 1); tick();
    apply_stimulus(32'h00, 0, 6'b0, 0, 1, 1); tick();
    check_output("ds_prior_pc", id_pc, 32'h1C);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(32'h00, 0, 6'b000110, 0, 1, 1); tick();
      check_output("ds_hold_pc", id_pc, 32'h1C);
      check_output("ds_hold_inst", id_inst, 32'hDEAD_001C);
      check_output("ds_hold_valid", id_valid, 1);
    end
    apply_stimulus(32'h00, 0, 6'b000010, 0, 1, 1); tick();
    check_output("ds_bubble_valid", id_valid, 0);
    check_output("ds_bubble_inst", id_inst, 32'h0);
    apply_stimulus(32'h00, 0, 6'b0, 0, 1, 1); tick();
    check_output("ds_load_pc", id_pc, 32'h20);
    check_output("ds_load_inst", id_inst, 32'hAA);
    drain(3);

    $display("[TB] flush with two in flight");
    apply_stimulus(32'h80, 1, 6'b0, 0, 1, 0); tick();
    apply_stimulus(32'h84, 1, 6'b0, 0, 1, 0); tick();
    apply_stimulus(32'h88, 1, 6'b0, 1, 1, 0); #3;
    check_output("fl_req", imem_req, 0);
    tick();
    check_output("fl_id_valid", id_valid, 0);
    apply_stimulus(32'h200, 1, 6'b0, 0, 1, 1); #3;
    check_output("fl_drop_req", imem_req, 0);
    check_output("fl_drop_stallreq", stallreq_if, 1);
    tick();
    apply_stimulus(32'h200, 1, 6'b0, 0, 1, 1); #3;
    check_output("fl_resume_req", imem_req, 1);
    tick();
    drain(1);
    check_output("fl_still_bubble", id_valid, 0);
    drain(1);
    check_output("fl_new_valid", id_valid, 1);
    check_output("fl_new_pc", id_pc, 32'h200);
    check_output("fl_new_inst", id_inst, 32'hDEAD_0200);
    drain(3);

    $display("[TB] flush with same-cycle response");
    apply_stimulus(32'h90, 1, 6'b0, 0, 1, 0); tick();
    apply_stimulus(32'h94, 1, 6'b0, 0, 1, 0); tick();
    apply_stimulus(32'h98, 1, 6'b0, 1, 1, 1); tick();
    apply_stimulus(32'h300, 1, 6'b0, 0, 1, 1); #3;
    check_output("fr_req", imem_req, 1);
    tick();
    drain(2);
    check_output("fr_new_pc", id_pc, 32'h300);
    check_output("fr_new_valid", id_valid, 1);
    drain(3);

    $display("[TB] async reset");
    apply_stimulus(32'h400, 1, 6'b0, 0, 1, 1); tick();
    apply_stimulus(32'h404, 1, 6'b0, 0, 1, 1); tick();
    apply_stimulus(32'h408, 1, 6'b0, 0, 1, 1); tick();
    check_output("ar_before_valid", id_valid, 1);
    apply_stimulus(32'h40C, 1, 6'b0, 0, 1, 1);
    #2;
    rst = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check_output("ar_id_valid", id_valid, 0);
    check_output("ar_id_pc", id_pc, 32'h0);
    check_output("ar_id_inst", id_inst, 32'h0);
    check_output("ar_imem_req", imem_req, 0);
    check_output("ar_stallreq", stallreq_if, 0);
    tick();
    check_output("ar_hold_req", imem_req, 0);
    rst = 1'b1;
    apply_stimulus(32'h500, 1, 6'b0, 0, 1, 1); tick();
    apply_stimulus(32'h504, 1, 6'b0, 0, 1, 1); tick();
    drain(1);
    check_output("ar_recover_pc", id_pc, 32'h500);
    drain(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
